// File: rtl/ctrl_pkg.sv
// Shared definitions for control-bundle pipeline stages: default bundle width,
// field bit positions, default bubble encoding and the bubble-stage state type.
package ctrl_pkg;

   // Default control bundle width: ALUSrc, RegDst, MemWr, MemRd, MemtoReg, RegWr, ALUOp[1:0]
   localparam int unsigned CtrlW = 8;

   // Bit positions of each field inside the default bundle
   localparam int unsigned BitAluSrc   = 7;
   localparam int unsigned BitRegDst   = 6;
   localparam int unsigned BitMemWr    = 5;
   localparam int unsigned BitMemRd    = 4;
   localparam int unsigned BitMemToReg = 3;
   localparam int unsigned BitRegWr    = 2;
   localparam int unsigned BitAluOpHi  = 1;
   localparam int unsigned BitAluOpLo  = 0;

   // Default bubble: every control asserted low, so a bubble has no side effects
   localparam logic [CtrlW-1:0] BubbleVal = '0;

   typedef enum logic [0:0] {
      StRun,
      StInject
   } bubble_state_e;

endpackage

// File: rtl/bubble_down_counter.sv
// Load/decrement/hold/clear counter tracking how many bubbles of a run are still
// owed after the current one. last_o flags the final outstanding bubble.
module bubble_down_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             last_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear wins over load, load over decrement, otherwise hold
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Count register with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == CNT_W'(1));

endmodule

// File: rtl/ctrl_bubble_stage.sv
// Registered control-bundle stage between decode and execute with stall, flush
// and programmable bubble-run injection. Optional injected-bubble statistics
// counter is built when CTRL_BUBBLE_STATS_EN is defined.
module ctrl_bubble_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned       CTRL_W      = ctrl_pkg::CtrlW,
   parameter int unsigned       MAX_BUBBLES = 3,
   parameter int unsigned       CNT_W       = $clog2(MAX_BUBBLES + 1),
   parameter logic [CTRL_W-1:0] BUBBLE_VAL  = CTRL_W'(ctrl_pkg::BubbleVal)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic              valid_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              bubble_req_i,
   input  logic [CNT_W-1:0]  bubble_cnt_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              valid_o,
   output logic              ready_o
`ifdef CTRL_BUBBLE_STATS_EN
   ,
   output logic [15:0]       bubble_count_o
`endif
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BUBBLES);

   bubble_state_e     state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              valid_q, valid_d;

   logic [CNT_W-1:0]  req_n;
   logic              req_fire;
   logic              bubble_wr;
   logic              cnt_clear, cnt_load, cnt_dec;
   logic [CNT_W-1:0]  cnt_load_val;
   logic [CNT_W-1:0]  remaining;
   logic              remaining_last;

   // Clamp the requested run length and decide whether a request is accepted
   always_comb begin
      req_n    = (bubble_cnt_i > MaxCnt) ? MaxCnt : bubble_cnt_i;
      req_fire = (state_q == StRun) && bubble_req_i && (req_n != '0);
   end

   // Next-state and bundle selection; priority is flush > stall > bubble > pass
   always_comb begin
      state_d      = state_q;
      ctrl_d       = ctrl_q;
      valid_d      = valid_q;
      cnt_clear    = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = '0;
      bubble_wr    = 1'b0;
      if (flush_i) begin
         ctrl_d    = BUBBLE_VAL;
         valid_d   = 1'b0;
         cnt_clear = 1'b1;
         state_d   = StRun;
      end else if (!stall_i) begin
         unique case (state_q)
            StRun: begin
               if (req_fire) begin
                  ctrl_d       = BUBBLE_VAL;
                  valid_d      = 1'b0;
                  cnt_load     = 1'b1;
                  cnt_load_val = req_n - CNT_W'(1);
                  bubble_wr    = 1'b1;
                  state_d      = (req_n > CNT_W'(1)) ? StInject : StRun;
               end else begin
                  ctrl_d  = ctrl_i;
                  valid_d = valid_i;
               end
            end
            StInject: begin
               ctrl_d    = BUBBLE_VAL;
               valid_d   = 1'b0;
               cnt_dec   = 1'b1;
               bubble_wr = 1'b1;
               if (remaining_last) begin
                  state_d = StRun;
               end
            end
            default: begin
               state_d = StRun;
            end
         endcase
      end
   end

   // Stage registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StRun;
         ctrl_q  <= BUBBLE_VAL;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   bubble_down_counter #(
      .CNT_W (CNT_W)
   ) u_remaining (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (cnt_clear),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .count_o    (remaining),
      .last_o     (remaining_last)
   );

   // Back-pressure upstream while holding or while a bubble occupies the slot;
   // flush deliberately does not lower ready
   always_comb begin
      ready_o = !stall_i && (state_q != StInject) && !req_fire;
   end

   assign ctrl_o  = ctrl_q;
   assign valid_o = valid_q;

`ifdef CTRL_BUBBLE_STATS_EN
   logic [15:0] bubble_count_q, bubble_count_d;

   // Saturating count of bubbles written by a request or an ongoing run
   always_comb begin
      bubble_count_d = bubble_count_q;
      if (bubble_wr && (bubble_count_q != 16'hFFFF)) begin
         bubble_count_d = bubble_count_q + 16'd1;
      end
   end

   // Statistics register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_count_q <= '0;
      end else begin
         bubble_count_q <= bubble_count_d;
      end
   end

   assign bubble_count_o = bubble_count_q;
`endif

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Self-checking bench for ctrl_bubble_stage: directed scenarios followed by
// randomized traffic, all compared against a run-length reference model.
module tb_ctrl_bubble_stage;

   localparam int unsigned MaxB = 3;

   logic       clk_i;
   logic       rst_i;
   logic [7:0] ctrl_i;
   logic       valid_i;
   logic       stall_i;
   logic       flush_i;
   logic       bubble_req_i;
   logic [2:0] bubble_cnt_i;
   logic [7:0] ctrl_o;
   logic       valid_o;
   logic       ready_o;
`ifdef CTRL_BUBBLE_STATS_EN
   logic [15:0] bubble_count_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: bundle on the output, bubbles still owed, bubbles injected
   logic [7:0] m_ctrl;
   logic       m_valid;
   int         m_left;
   int         m_cnt;

   ctrl_bubble_stage #(
      .CTRL_W      (8),
      .MAX_BUBBLES (MaxB),
      .CNT_W       (3),
      .BUBBLE_VAL  (8'h00)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ctrl_i         (ctrl_i),
      .valid_i        (valid_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .bubble_req_i   (bubble_req_i),
      .bubble_cnt_i   (bubble_cnt_i),
      .ctrl_o         (ctrl_o),
      .valid_o        (valid_o),
      .ready_o        (ready_o)
`ifdef CTRL_BUBBLE_STATS_EN
      ,
      .bubble_count_o (bubble_count_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ctrl  = 8'h00;
      m_valid = 1'b0;
      m_left  = 0;
      m_cnt   = 0;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".ctrl"}, 32'(ctrl_o), 32'(m_ctrl));
      check_val({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
`ifdef CTRL_BUBBLE_STATS_EN
      check_val({tag, ".count"}, 32'(bubble_count_o), 32'(m_cnt));
`endif
   endtask

   // Drive one cycle, check ready before the edge and the stage after it
   task automatic cycle(input string tag, input logic [7:0] c, input logic v, input logic st,
                        input logic fl, input logic rq, input logic [2:0] cnt);
      int n;
      ctrl_i       = c;
      valid_i      = v;
      stall_i      = st;
      flush_i      = fl;
      bubble_req_i = rq;
      bubble_cnt_i = cnt;
      n = (int'(cnt) > int'(MaxB)) ? int'(MaxB) : int'(cnt);
      #1;
      check_val({tag, ".ready"}, 32'(ready_o),
                32'(!st && (m_left == 0) && !(rq && (n > 0))));
      if (fl) begin
         m_ctrl  = 8'h00;
         m_valid = 1'b0;
         m_left  = 0;
      end else if (st) begin
         // hold everything
      end else if (m_left > 0) begin
         m_ctrl  = 8'h00;
         m_valid = 1'b0;
         m_left  = m_left - 1;
         if (m_cnt < 65535) m_cnt++;
      end else if (rq && (n > 0)) begin
         m_ctrl  = 8'h00;
         m_valid = 1'b0;
         m_left  = n - 1;
         if (m_cnt < 65535) m_cnt++;
      end else begin
         m_ctrl  = c;
         m_valid = v;
      end
      @(posedge clk_i);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      rst_i        = 1'b0;
      ctrl_i       = 8'hA5;
      valid_i      = 1'b1;
      stall_i      = 1'b0;
      flush_i      = 1'b0;
      bubble_req_i = 1'b0;
      bubble_cnt_i = '0;
      model_reset();

      // Held in reset: outputs stay at bubble value despite live input
      #1;
      check_outputs("rst0");
      check_val("rst0.ready", 32'(ready_o), 32'd1);
      repeat (3) begin
         @(posedge clk_i);
         #1;
         check_outputs("rst_hold");
      end
      rst_i = 1'b1;

      // First edge after release captures A5
      cycle("rel", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Plain pass-through
      cycle("pt1", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("pt2", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("pt3", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

      // Three-bubble run with 44 pending; 44 lands on the fourth edge
      cycle("b3a", 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
      cycle("b3b", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("b3c", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("b3d", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Clamp: 7 requested behaves as 3; requests during the run are ignored
      cycle("clpa", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
      cycle("clpb", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
      cycle("clpc", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
      cycle("clpd", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Zero-length request is pass-through; length one stays out of INJECT
      cycle("zero", 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
      cycle("one", 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
      cycle("onep", 8'h78, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Stall in INJECT with one bubble left: run stretches by two cycles
      cycle("sta", 8'h88, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
      cycle("stb", 8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("st1", 8'h88, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      cycle("st2", 8'h88, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      cycle("stc", 8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("std", 8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Stall of a real instruction holds it
      cycle("sh1", 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

      // Flush in INJECT: back to RUN, no extra count
      cycle("fla", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
      cycle("flf", 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      cycle("flp", 8'hAB, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("fls", 8'hAC, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);

      // Mid-run reset: asynchronous, clears count and remaining
      cycle("mra", 8'hBB, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
      cycle("mrb", 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      rst_i = 1'b0;
      model_reset();
      #1;
      check_outputs("mrst");
      #3;
      rst_i = 1'b1;
      cycle("mrp1", 8'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      cycle("mrp2", 8'hC2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Asynchronous reset clears a live instruction without a clock edge
      rst_i = 1'b0;
      model_reset();
      #1;
      check_outputs("arst");
      #3;
      rst_i = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rnd", 8'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ctrl_bubble_stage.md
# ctrl_bubble_stage

Registered control-bundle stage between decode and execute that replaces the combinational zero-on-hazard control mux. Decoded control fields pass through one register stage. The stage adds several hazard controls: whole-stage stall (hold), flush (squash), and injection of a programmable run of N bubbles for multi-cycle hazards. While it is injecting, it back-pressures upstream. The control bundle width and bubble encoding are parametrised so the block serves every control-bearing pipeline boundary.

## Interface
- CTRL_W, default 8: control bundle width (ALUSrc, RegDst, MemWr, MemRd, MemtoReg, RegWr, ALUOp[1:0]).
- MAX_BUBBLES, default 3: largest bubble run accepted per request.
- CNT_W, default $clog2(MAX_BUBBLES+1): width of bubble_cnt_i.
- BUBBLE_VAL, default {CTRL_W{1'b0}}: bundle value written for a bubble.
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ctrl_i  input  CTRL_W  decoded control bundle from decode.
- valid_i  input  1  ctrl_i carries a real instruction.
- stall_i  input  1  hold stage contents this cycle.
- flush_i  input  1  squash stage contents this cycle.
- bubble_req_i  input  1  request a bubble run, sampled only in RUN.
- bubble_cnt_i  input  CNT_W  requested run length; clamped to MAX_BUBBLES.
- ctrl_o  output  CTRL_W  registered control bundle to execute.
- valid_o  output  1  ctrl_o carries a real instruction.
- ready_o  output  1  upstream may advance; combinational.
- bubble_count_o  output  16  injected-bubble counter; present only with CTRL_BUBBLE_STATS_EN.

## Operation
- States: RUN, INJECT. Register `remaining` has CNT_W bits.
- Reset values: state=RUN, ctrl_o=BUBBLE_VAL, valid_o=0, remaining=0, bubble_count_o=0. ready_o evaluates to 1 out of reset.
- Per-edge priority is flush > stall > bubble request/INJECT > pass-through.
- Flush, in any state: ctrl_o←BUBBLE_VAL, valid_o←0, remaining←0, state←RUN. Flush does not count as an injected bubble.
- Stall, with no flush: ctrl_o, valid_o, remaining and state all hold.
- RUN with bubble_req_i=1 and clamped count n≥1: ctrl_o←BUBBLE_VAL, valid_o←0, remaining←n−1. state←INJECT if n>1, otherwise it stays RUN.
- RUN with bubble_req_i=1 and n=0: treated as pass-through.
- RUN pass-through: ctrl_o←ctrl_i, valid_o←valid_i.
- INJECT, with no flush or stall: ctrl_o←BUBBLE_VAL, valid_o←0, remaining←remaining−1. state←RUN when remaining==1. bubble_req_i is ignored.
- ready_o = !stall_i && !(state==INJECT) && !(state==RUN && bubble_req_i && n≥1). flush_i does not lower ready_o.
- Clamp rule: a bubble_cnt_i value above MAX_BUBBLES is treated as MAX_BUBBLES.

## Timing
- Pass-through latency is one cycle: ctrl_i at edge k appears on ctrl_o after edge k.
- A request for n bubbles produces exactly n consecutive bubble cycles on ctrl_o, excluding stalled cycles. ready_o is low for those same n cycles; the first low cycle is the request cycle.
- A stall in INJECT extends the run by one cycle per stalled cycle. remaining does not decrement while stalled.
- Reset asserted mid-run returns the stage to reset values immediately, without waiting for a clock edge.

## Configuration
- CTRL_BUBBLE_STATS_EN defined:
  - bubble_count_o exists.
  - It increments by 1 on each edge that writes a bubble because of a request or INJECT.
  - It saturates at 16'hFFFF.
  - Flush and stall cycles never increment it.
- CTRL_BUBBLE_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package ctrl_pkg holds:
  - CTRL_W default;
  - bit-position localparams for each control field;
  - the default BUBBLE_VAL;
  - the state enum {RUN, INJECT}.
- One sub-module, bubble_down_counter, implements the load/decrement/hold/clear logic for `remaining`. It reports last = (remaining==1).

## Test plan
- Reset with ctrl_i=8'hA5 and valid_i=1: ctrl_o=0 and valid_o=0 until release. On the first edge after release, ctrl_o=8'hA5 and valid_o=1.
- Pass-through sequence 8'h11, 8'h22, 8'h33: each appears one cycle later, and ready_o stays 1.
- bubble_req_i=1, bubble_cnt_i=3:
  - three cycles of ctrl_o=0/valid_o=0, with ready_o=0 for those three cycles;
  - the pending ctrl_i=8'h44 appears on the fourth edge;
  - bubble_count_o=3 with the macro defined.
- bubble_cnt_i=7 with MAX_BUBBLES=3 is clamped to 3 bubbles. bubble_cnt_i=0 gives pass-through.
- Stall during INJECT, with remaining=1 and stall_i high for 2 cycles: outputs and remaining hold, and the run ends 2 cycles later. Flush in INJECT returns to RUN with remaining=0 and no count increment.
- Mid-run reset: assert rst_i low during INJECT, then release. The stage resumes in RUN with remaining=0 and bubble_count_o=0.
